btn_mem_writer: RTL and testbench

BTN_MEM_WRITER -- requirements
Module: btn_mem_writer

---
 rtl/btn_mem_writer_pkg.sv | 41 ++++
 rtl/btn_debounce.sv | 105 ++++++++++
 rtl/btn_mem_writer.sv | 113 +++++++++++
 tb/tb_btn_mem_writer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_mem_writer_pkg.sv
// Shared types and constants for the button-driven memory writer:
// FSM state encoding, bus widths, button bit assignments and the
// wrapping address increment used by both manual and automatic stepping.
package btn_mem_writer_pkg;

    // Width of the RAM-stage write address and write data buses.
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    // Number of raw keys and their bit positions on the btn bus.
    localparam int BTN_W      = 3;
    localparam int BTN_DATA   = 0;
    localparam int BTN_ADDR   = 1;
    localparam int BTN_COMMIT = 2;

    // Mask selecting the commit key out of a per-key level vector.
    localparam logic [BTN_W-1:0] BTN_COMMIT_MASK = BTN_W'(1) << BTN_COMMIT;

    // Depth of the metastability synchronizer on each raw key.
    localparam int SYNC_STAGES = 2;

    // Writer FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WRITE        = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_e;

    // Next write address with wrap: anything at or beyond the limit
    // returns to zero, so the address can never exceed the limit.
    function automatic logic [ADDR_W-1:0] addr_wrap_inc(
        input logic [ADDR_W-1:0] cur,
        input logic [ADDR_W-1:0] limit
    );
        if (cur >= limit) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

endpackage : btn_mem_writer_pkg

// File: rtl/btn_debounce.sv
// One raw active-low key: 2-FF synchronizer, counting debouncer and a
// registered press pulse. The accepted level only flips after
// DEBOUNCE_CYCLES consecutive cycles of a differing synchronized level;
// any bounce back to the accepted level restarts the count.
//
// Press pulses are held off after reset until the key has been seen
// released (either a debounced release, or a released input for the full
// synchronizer plus debounce window). A key held through reset therefore
// yields nothing until it is let go and pressed again.
module btn_debounce
    import btn_mem_writer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    // Counter must hold both the debounce window and the post-reset
    // settle window (debounce window plus synchronizer depth).
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + SYNC_STAGES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   prev_q, prev_d;
    logic                   press_q, press_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       settle_q, settle_d;
    logic                   raw_pressed;

    // Synchronized key in pressed-high polarity.
    assign raw_pressed = ~sync_q[SYNC_STAGES-1];

    // Next-state logic for synchronizer, debouncer, edge detector and arming.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned, which would otherwise infer a latch.
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_n};
        level_d  = level_q;
        cnt_d    = '0;
        prev_d   = level_q;
        armed_d  = armed_q;
        settle_d = settle_q;

        // Count consecutive cycles of disagreement; accept on the last one.
        if (raw_pressed != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Arm once the key is known to have been released since reset.
        if (!armed_q) begin
            if (level_q && !level_d) begin
                armed_d = 1'b1;
            end else if (!raw_pressed && !level_q) begin
                if (settle_q == SETTLE_LAST) begin
                    armed_d = 1'b1;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end else begin
                settle_d = '0;
            end
        end

        // One-cycle pulse on the accepted released-to-pressed transition.
        press_d = armed_q & level_q & ~prev_q;
    end

    // State registers; reset puts every key in the released, unarmed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            level_q  <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            press_q  <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values from before this edge, independent of statement order.
            sync_q   <= sync_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            press_q  <= press_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule : btn_debounce

// File: rtl/btn_mem_writer.sv
// Button-driven RAM writer. Three raw active-low keys step the data
// value, step the write address (wrapping at ADDR_MAX) and commit one
// write. A commit produces a single-cycle wren with addr/data held
// stable, then the FSM waits for the commit key to be released before
// accepting further key events.
//
// Build option BTN_MEM_WRITER_AUTOINC_EN: when defined, the address also
// advances (with wrap) on the cycle after each write.
module btn_mem_writer
    import btn_mem_writer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_MAX        = 255,
    parameter int DATA_STEP       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BTN_W-1:0]  btn,
    output logic              wren,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_MAX);
    localparam logic [DATA_W-1:0] DATA_INC   = DATA_W'(DATA_STEP);

    logic [BTN_W-1:0]  level;
    logic [BTN_W-1:0]  press;
    logic              commit_held;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // One debouncer and press detector per key.
    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (reset),
            .btn_n (btn[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    // Accepted (debounced) level of the commit key.
    assign commit_held = |(level & BTN_COMMIT_MASK);

    // Next-state, address and data update; commit outranks address, which
    // outranks data, and lower-priority events in the same cycle are dropped.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                if (press[BTN_COMMIT]) begin
                    state_d = WRITE;
                end else if (press[BTN_ADDR]) begin
                    addr_d = addr_wrap_inc(addr_q, ADDR_LIMIT);
                end else if (press[BTN_DATA]) begin
                    data_d = data_q + DATA_INC;
                end
            end

            WRITE: begin
                // addr/data are untouched here, so they are stable under wren.
                state_d = WAIT_RELEASE;
`ifdef BTN_MEM_WRITER_AUTOINC_EN
                // Advance at the edge that ends WRITE, after the write lands.
                addr_d = addr_wrap_inc(addr_q, ADDR_LIMIT);
`else
                addr_d = addr_q;
`endif
            end

            WAIT_RELEASE: begin
                // Address/data events are ignored until commit is let go.
                if (!commit_held) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, address and data registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode straight from flops, so reset drops wren immediately.
    assign wren = (state_q == WRITE);
    assign busy = (state_q != IDLE);
    assign addr = addr_q;
    assign data = data_q;

endmodule : btn_mem_writer

// File: tb/tb_btn_mem_writer.sv
// Directed bench for btn_mem_writer with DEBOUNCE_CYCLES = 4, ADDR_MAX = 3,
// DATA_STEP = 1. Inputs change and outputs are sampled on the falling edge.
// Latency from driving a key low to the WRITE cycle: 2 synchronizer edges,
// 4 debounce edges, 1 edge for the press pulse, 1 edge into WRITE = 8.
module tb_btn_mem_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  btn;
    logic        wren;
    logic [15:0] addr;
    logic [31:0] data;
    logic        busy;

    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_total  = 0;
    int          wren_cnt = 0;
    logic [15:0] wr_addr  = '0;
    logic [31:0] wr_data  = '0;

    btn_mem_writer #(
        .DEBOUNCE_CYCLES (4),
        .ADDR_MAX        (3),
        .DATA_STEP       (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .wren  (wren),
        .addr  (addr),
        .data  (data),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Record every write the RAM stage would see.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            wren_cnt = wren_cnt + 1;
            wr_addr  = addr;
            wr_data  = data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press and release of one key, each held well past debounce.
    task automatic tap(input int idx);
        btn[idx] = 1'b0;
        cycles(12);
        btn[idx] = 1'b1;
        cycles(12);
    endtask

    // Count falling edges until wren is seen, bounded at 30.
    task automatic wait_wren(output int cyc);
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (wren === 1'b1) break;
        end
    endtask

    int          lat;
    int          snap;
    logic [15:0] addr_seq [4];

    initial begin
        btn   = 3'b111;
        reset = 1'b0;
        cycles(3);

        // Reset state.
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_data", data, 32'd0);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        cycles(10);

        // Three clean data presses.
        tap(0); tap(0); tap(0);
        check("data_after_3", data, 32'd3);
        check("addr_after_data", 32'(addr), 32'd0);

        // Commit: one write at addr 0 with data 3, busy until release.
        snap = wren_cnt;
        btn[2] = 1'b0;
        wait_wren(lat);
        check("commit_latency", 32'(lat), 32'd8);
        check("commit_addr", 32'(addr), 32'd0);
        check("commit_data", data, 32'd3);
        check("commit_busy", 32'(busy), 32'd1);
        cycles(10);
        check("commit_one_wren", 32'(wren_cnt - snap), 32'd1);
        check("commit_busy_held", 32'(busy), 32'd1);
        btn[2] = 1'b1;
        cycles(12);
        check("commit_busy_released", 32'(busy), 32'd0);

        // Address stepping with wrap at 3.
`ifdef BTN_MEM_WRITER_AUTOINC_EN
        addr_seq[0] = 16'd2; addr_seq[1] = 16'd3; addr_seq[2] = 16'd0; addr_seq[3] = 16'd1;
`else
        addr_seq[0] = 16'd1; addr_seq[1] = 16'd2; addr_seq[2] = 16'd3; addr_seq[3] = 16'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            tap(1);
            check($sformatf("addr_step_%0d", i), 32'(addr), 32'(addr_seq[i]));
        end

`ifdef BTN_MEM_WRITER_AUTOINC_EN
        // From addr 1, two steps to 3, then a commit writes at 3 and wraps.
        tap(1); tap(1);
        check("autoinc_pre_addr", 32'(addr), 32'd3);
        tap(2);
        check("autoinc_wr_addr", 32'(wr_addr), 32'd3);
        check("autoinc_post_addr", 32'(addr), 32'd0);
`endif

        // Bouncing data key: 2-cycle toggles never satisfy a 4-cycle window.
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            cycles(2);
        end
        check("bounce_no_change", data, 32'd3);
        tap(0);
        check("bounce_single_inc", data, 32'd4);

        // Address and commit accepted together: commit wins.
        snap = wren_cnt;
        btn = 3'b001;
        wait_wren(lat);
        check("simul_latency", 32'(lat), 32'd8);
        check("simul_wr_addr", 32'(addr), 32'd0);
        check("simul_wr_data", data, 32'd4);
        cycles(10);
        check("simul_one_wren", 32'(wren_cnt - snap), 32'd1);
`ifdef BTN_MEM_WRITER_AUTOINC_EN
        check("simul_addr_after", 32'(addr), 32'd1);
`else
        check("simul_addr_after", 32'(addr), 32'd0);
`endif
        btn = 3'b111;
        cycles(12);
        check("simul_busy_released", 32'(busy), 32'd0);

        // Reset during WRITE: wren drops asynchronously.
        btn[2] = 1'b0;
        wait_wren(lat);
        check("rst_write_latency", 32'(lat), 32'd8);
        #1 reset = 1'b0;
        #1;
        check("rst_wren_async", 32'(wren), 32'd0);
        check("rst_busy_async", 32'(busy), 32'd0);
        check("rst_addr_async", 32'(addr), 32'd0);
        check("rst_data_async", data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        snap = wren_cnt;

        // Commit key held through reset: no write until re-pressed.
        cycles(15);
        check("held_no_write", 32'(wren_cnt - snap), 32'd0);
        check("held_not_busy", 32'(busy), 32'd0);
        btn[2] = 1'b1;
        cycles(12);
        btn[2] = 1'b0;
        wait_wren(lat);
        check("repress_latency", 32'(lat), 32'd8);
        check("repress_addr", 32'(addr), 32'd0);
        check("repress_data", data, 32'd0);
        btn[2] = 1'b1;
        cycles(12);
        check("repress_one_wren", 32'(wren_cnt - snap), 32'd1);
        check("repress_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_btn_mem_writer
